// File: rtl/seq_divider.sv
// Purpose : multi-cycle restoring divider (signed/unsigned) feeding the ALU Z / HI-LO path.
// Latency : done pulses WIDTH+1 edges after the accepted start (1 edge for a zero divisor
//           when SEQ_DIVIDER_ZERO_FASTPATH_EN is defined).
// Backpressure: none; start is ignored while busy, the next start is accepted in the done cycle.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   start      one-cycle request, sampled only while idle
//   is_signed  1 = two's-complement operands (sampled with start)
//   dividend   dividend (sampled with start)
//   divisor    divisor (sampled with start)
//   busy       high while a division is in progress
//   done       one-cycle pulse when quotient/remainder/div_zero update
//   quotient   quotient (LO), held until the next result
//   remainder  remainder (HI), held until the next result
//   div_zero   divisor was zero, held with the results
//
// Optional feature macro: SEQ_DIVIDER_ZERO_FASTPATH_EN
//   defined   -> a zero divisor skips the iterations and goes straight to FIX
//   undefined -> a zero divisor runs all iterations; results are forced at FIX

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // The LOAD step is folded into the IDLE start edge, so it has no state of its own.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p;          // partial remainder (always < divisor magnitude)
  logic [WIDTH-1:0] r_q;          // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;        // divisor magnitude
  logic [WIDTH-1:0] r_dividend;   // raw dividend, returned as remainder on divide by zero
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dvs_zero;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [1:0]       w_load_next;

  // Magnitudes stay WIDTH-bit unsigned: the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // Trial subtraction on WIDTH+1 bits; the top bit of the difference is the borrow.
  // Because r_p < divisor, a non-negative difference always fits back in WIDTH bits.
  assign w_p_shift = {r_p, r_q[WIDTH-1]};
  assign w_diff    = w_p_shift - {1'b0, r_dvs};
  assign w_fits    = ~w_diff[WIDTH];

  // Quotient truncates toward zero; the remainder follows the dividend's sign.
  assign w_quo_fix = r_q_neg ? (~r_q + 1'b1) : r_q;
  assign w_rem_fix = r_r_neg ? (~r_p + 1'b1) : r_p;

`ifdef SEQ_DIVIDER_ZERO_FASTPATH_EN
  assign w_load_next = (divisor == '0) ? S_FIX : S_RUN;
`else
  assign w_load_next = S_RUN;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_dividend  <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dvs_zero  <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_dvs      <= w_b_mag;
            r_q        <= w_a_mag;
            r_p        <= '0;
            r_cnt      <= '0;
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_dvs_zero <= (divisor == '0);
            r_state    <= w_load_next;
          end
        end
        S_RUN: begin
          // A failed trial keeps the shifted remainder (its top bit is 0 in that case).
          r_p   <= w_fits ? w_diff[WIDTH-1:0] : w_p_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_dvs_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_div_zero  <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed test-plan cases plus randomized divisions,
// each checked against an arithmetic reference model and a cycle-accurate expectation of
// busy/done/result timing.

module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge m, cyc == m.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: actual %h required %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the specification's rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    longint sa, sb, lq, lr;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      lq = sa / sb;
      lr = sa % sb;
      q = lq[W-1:0]; r = lr[W-1:0]; dz = 1'b0;
    end
  endfunction

  // Model state: one division in flight at most.
  logic          pending = 1'b0;
  int            exp_done_cyc = 0;
  int            free_from = 0;      // earliest edge at which a start is accepted
  logic [W-1:0]  exp_q, exp_r;
  logic          exp_dz;
  logic [W-1:0]  held_q = '0, held_r = '0;
  logic          held_dz = 1'b0;
  logic          exp_busy, exp_done;

  task automatic model_reset();
    pending   = 1'b0;
    free_from = 0;
    held_q    = '0;
    held_r    = '0;
    held_dz   = 1'b0;
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!clr_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_zero", div_zero, 0);
    end else begin
      exp_busy = pending && (cyc < exp_done_cyc);
      exp_done = pending && (cyc == exp_done_cyc);
      if (exp_done) begin
        held_q  = exp_q;
        held_r  = exp_r;
        held_dz = exp_dz;
        pending = 1'b0;
      end
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("quotient", quotient, held_q);
      chk("remainder", remainder, held_r);
      chk("div_zero", div_zero, held_dz);
    end
  end

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int k;
    logic [W-1:0] q, r;
    logic dz;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
    if (clr_n && k >= free_from) begin
      model(a, b, s, q, r, dz);
      exp_q        = q;
      exp_r        = r;
      exp_dz       = dz;
      exp_done_cyc = k + ((b == '0) ? ZLAT : W + 1);
      pending      = 1'b1;
      free_from    = exp_done_cyc + 1;
    end
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 200);
    chk({nm, "_done_seen"}, done, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pending && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", pending, 0);
  endtask

  task automatic run_case(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat);
    int lat;
    do_start(a, b, s);
    wait_done(nm, lat);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dz"}, div_zero, edz);
  endtask

  initial begin
    logic [W-1:0] mq, mr, ra, rb;
    logic mdz, rs;
    int lat;

    clr_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_dz", div_zero, 0);
    #2 clr_n = 1'b1;

    // Pin the model against hand-computed values.
    model(32'd100, 32'd7, 1'b0, mq, mr, mdz);
    chk("model_u100_7_q", mq, 32'd14); chk("model_u100_7_r", mr, 32'd2);
    model(32'hFFFFFF9C, 32'd7, 1'b1, mq, mr, mdz);
    chk("model_sm100_7_q", mq, 32'hFFFFFFF2); chk("model_sm100_7_r", mr, 32'hFFFFFFFE);
    model(32'd100, 32'hFFFFFFF9, 1'b1, mq, mr, mdz);
    chk("model_s100_m7_q", mq, 32'hFFFFFFF2); chk("model_s100_m7_r", mr, 32'd2);
    model(32'h80000000, 32'hFFFFFFFF, 1'b1, mq, mr, mdz);
    chk("model_ovf_q", mq, 32'h80000000); chk("model_ovf_r", mr, 32'd0);
    model(32'h12345678, 32'd0, 1'b1, mq, mr, mdz);
    chk("model_dz_q", mq, 32'hFFFFFFFF); chk("model_dz_r", mr, 32'h12345678);
    chk("model_dz_flag", mdz, 1);

    // Directed test-plan cases (back-to-back: each next start lands in the done cycle).
    run_case("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0, W + 1);
    run_case("sm100_7",  32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, W + 1);
    run_case("s100_m7",  32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, W + 1);
    run_case("umax_2",   32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF, 32'd1,        1'b0, W + 1);
    run_case("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, W + 1);
    run_case("dz_u",     32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, ZLAT);
    run_case("dz_s",     32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, ZLAT);
    run_case("u100_7b",  32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0, W + 1);

    // start while busy (10 edges into a division) must be ignored.
    wait_idle();
    do_start(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    do_start(32'd55, 32'd5, 1'b1);
    wait_done("ignore", lat);
    chk("ignore_q", quotient, 32'd333);
    chk("ignore_r", remainder, 32'd1);

    // Reset in the middle of a division.
    wait_idle();
    do_start(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    #1 clr_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dz", div_zero, 0);
    repeat (2) @(negedge clk);
    #2 clr_n = 1'b1;
    run_case("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W + 1);

    // Randomized divisions, with occasional stray starts while busy.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'h80000000;
        default: rb = $urandom >> $urandom_range(0, 28);
      endcase
      rs = 1'($urandom_range(0, 1));
      do_start(ra, rb, rs);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 28)) @(posedge clk);
        do_start($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
